// File: rtl/signed_requantizer_if.sv
// Valid/ready stream bundle for the requantizer: wide signed samples in,
// narrowed samples plus a per-sample clip flag out.
interface signed_requantizer_if #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [IN_WIDTH-1:0]    in_data;
  logic [SHIFT_WIDTH-1:0] in_shift;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_WIDTH-1:0]   out_data;
  logic                   out_sat;

  modport master (
    output in_valid, in_data, in_shift, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_shift, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/signed_requantizer.sv
// Two-stage requantizer: S1 does a rounding arithmetic right shift, S2 saturates
// to OUT_WIDTH. Full backpressure; sticky counter of clipped outputs handed off.
module signed_requantizer #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  signed_requantizer_if.slave        bus,
  input  logic                       sat_clear,
  output logic [CNT_WIDTH-1:0]       sat_count
);

  typedef logic signed [IN_WIDTH:0] acc_t;

  localparam int SA_W  = $clog2(IN_WIDTH);
  localparam int CMP_W = ((SHIFT_WIDTH > SA_W) ? SHIFT_WIDTH : SA_W) + 1;
  localparam logic [CMP_W-1:0] MAX_SHIFT = CMP_W'(IN_WIDTH - 1);

  localparam acc_t SAT_MAX = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam acc_t SAT_MIN = {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic                 s1_valid_q, s1_valid_d;
  acc_t                 s1_r_q, s1_r_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_sat_q, out_sat_d;
  logic [CNT_WIDTH-1:0] sat_count_q, sat_count_d;

  logic                 adv1, adv2, out_fire;
  logic [CMP_W-1:0]     shift_ext;
  logic [SA_W-1:0]      s_amt;
  acc_t                 ext, bias, sum, r;
  logic [OUT_WIDTH-1:0] sat_data;
  logic                 sat_flag;

  assign adv2     = !out_valid_q || bus.out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign out_fire = out_valid_q && bus.out_ready;

  // S1: clamp the shift, add half an LSB of the result, then shift arithmetically.
  // The extra top bit keeps the rounding add from overflowing.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    shift_ext = CMP_W'(bus.in_shift);
    s_amt     = (shift_ext > MAX_SHIFT) ? SA_W'(MAX_SHIFT) : SA_W'(shift_ext);
    ext       = {bus.in_data[IN_WIDTH-1], bus.in_data};
    bias      = '0;
    sum       = ext;
    r         = ext;
    if (s_amt != '0) begin
      bias = acc_t'(1) << (s_amt - SA_W'(1));
      sum  = ext + bias;
      r    = sum >>> s_amt;
    end
  end

  always_comb begin
    sat_data = s1_r_q[OUT_WIDTH-1:0];
    sat_flag = 1'b0;
    if (s1_r_q > SAT_MAX) begin
      sat_data = OUT_MAX;
      sat_flag = 1'b1;
    end else if (s1_r_q < SAT_MIN) begin
      sat_data = OUT_MIN;
      sat_flag = 1'b1;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_r_d      = s1_r_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sat_count_d = sat_count_q;

    if (adv1) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) s1_r_d = r;
    end

    // S2 only reloads on advance, so a stalled output stays stable.
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = sat_data;
        out_sat_d  = sat_flag;
      end
    end

    if (sat_clear) begin
      sat_count_d = '0;
    end else if (out_fire && out_sat_q && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_r_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_r_q      <= s1_r_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign sat_count     = sat_count_q;

endmodule
